// File: rtl/sr_latch_reader_pkg.sv
// Shared definitions for the SR latch reader: FSM state encoding,
// event counter width and the default timing parameters.
package sr_latch_reader_pkg;

  localparam int EVT_CNT_W           = 8;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int CLR_CYCLES_DEF      = 4;
  localparam int TIMEOUT_CYCLES_DEF  = 16;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRESENT  = 3'd1;
  localparam logic [STATE_W-1:0] ST_CLEAR    = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_CLR = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT    = 3'd4;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit. Reset loads RST_VAL
// into every stage so the output shows a known level straight away.
module bit_synchronizer #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sr_latch_reader.sv
// Watches an external NAND SR latch, reports each set as an event, then
// pulses the latch clear and checks that the latch really cleared.
module sr_latch_reader
  import sr_latch_reader_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int CLR_CYCLES     = CLR_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 latch_q,
  input  logic                 latch_qn,
  output logic                 latch_rn,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [EVT_CNT_W-1:0] evt_count,
  output logic                 fault,
  input  logic                 fault_clr,
  output logic [STATE_W-1:0]   dbg_state
);

  localparam int BLANK   = SYNC_STAGES + 1;
  localparam int CNT_MAX = (CLR_CYCLES > BLANK + TIMEOUT_CYCLES) ?
                           CLR_CYCLES : BLANK + TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BLANK + TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                 q_s, qn_s;
  logic [STATE_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 bad_q, bad_d;
  logic [EVT_CNT_W-1:0] evt_count_q, evt_count_d;
  logic                 evt_valid_q, latch_rn_q, fault_q;
  logic                 set_seen, clr_seen, illegal;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_q (
    .clk(clk), .reset(reset), .d_i(latch_q), .q_o(q_s)
  );

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_qn (
    .clk(clk), .reset(reset), .d_i(latch_qn), .q_o(qn_s)
  );

  assign set_seen = q_s & ~qn_s;
  assign clr_seen = ~q_s & qn_s;
  assign illegal  = ~(q_s ^ qn_s);

  // Handshake: evt_valid stays high while in PRESENT and drops only after
  // the clock edge that sees evt_valid and evt_ready both high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bad_d       = 1'b0;
    evt_count_d = evt_count_q;
    case (state_q)
      ST_IDLE: begin
        if (set_seen) begin
          state_d = ST_PRESENT;
        end else if (illegal) begin
          // One clock of q==qn is switching skew; two in a row is a fault.
          if (bad_q) state_d = ST_FAULT;
          else       bad_d   = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (evt_ready) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          if (evt_count_q != {EVT_CNT_W{1'b1}})
            evt_count_d = evt_count_q + EVT_CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = ST_WAIT_CLR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_CLR: begin
        // The first BLANK clocks still show pre-clear values from the synchronizers.
        if (cnt_q < BLANK_C) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (clr_seen) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (set_seen) begin
          state_d = ST_PRESENT;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      evt_count_q <= '0;
      evt_valid_q <= 1'b0;
      latch_rn_q  <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      evt_count_q <= evt_count_d;
      evt_valid_q <= (state_d == ST_PRESENT);
      latch_rn_q  <= (state_d != ST_CLEAR);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign latch_rn  = latch_rn_q;
  assign evt_valid = evt_valid_q;
  assign evt_count = evt_count_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_latch_reader.sv
// Directed bench for sr_latch_reader driving a behavioural NAND SR latch
// whose clear input is the DUT's latch_rn.
module tb_sr_latch_reader;
  import sr_latch_reader_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 latch_q, latch_qn, latch_rn;
  logic                 evt_valid, evt_ready;
  logic [EVT_CNT_W-1:0] evt_count;
  logic                 fault, fault_clr;
  logic [STATE_W-1:0]   dbg_state;

  logic set_n, dead, bad_pat, lat_state, rn_eff, both_low;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sr_latch_reader dut (
    .clk(clk), .reset(reset), .latch_q(latch_q), .latch_qn(latch_qn),
    .latch_rn(latch_rn), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_count(evt_count), .fault(fault), .fault_clr(fault_clr),
    .dbg_state(dbg_state)
  );

  // ---------------- latch model ----------------
  // dead: latch outputs stuck low and the clear input has no effect.
  // bad_pat: forces q=qn=1 at the pins. The latch powers up cleared with reset.
  assign rn_eff   = latch_rn | dead;
  assign both_low = ~set_n & ~rn_eff;

  always @(set_n or rn_eff or reset) begin
    if (reset && set_n)        lat_state = 1'b0;
    else if (!set_n && rn_eff) lat_state = 1'b1;
    else if (set_n && !rn_eff) lat_state = 1'b0;
  end

  assign latch_q  = dead ? 1'b0 : (bad_pat | both_low | lat_state);
  assign latch_qn = dead ? 1'b0 : (bad_pat | both_low | ~lat_state);

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    set_n     = 1'b1;
    evt_ready = 1'b0;
    fault_clr = 1'b0;
    dead      = 1'b0;
    bad_pat   = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_set();
    set_n = 1'b0;
    tick(1);
    set_n = 1'b1;
  endtask

  task automatic wait_state(input string tag, input logic [STATE_W-1:0] st, input int budget);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(dbg_state), 32'(st));
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    int exp_cnt;

    // reset state
    do_reset();
    check("rst_rn",    32'(latch_rn),  32'd1);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_fault", 32'(fault),     32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // set at cycle 0, consumer ready: valid at 3, clear 4-7, idle again
    evt_ready = 1'b1;
    pulse_set();
    check("s1_valid_c1", 32'(evt_valid), 32'd0);
    tick(1);
    check("s1_valid_c2", 32'(evt_valid), 32'd0);
    tick(1);
    check("s1_valid_c3", 32'(evt_valid), 32'd1);
    check("s1_rn_c3",    32'(latch_rn),  32'd1);
    check("s1_state_c3", 32'(dbg_state), 32'(ST_PRESENT));
    tick(1);
    check("s1_rn_c4",    32'(latch_rn),  32'd0);
    check("s1_valid_c4", 32'(evt_valid), 32'd0);
    check("s1_count_c4", 32'(evt_count), 32'd1);
    tick(3);
    check("s1_rn_c7",    32'(latch_rn),  32'd0);
    tick(1);
    check("s1_rn_c8",    32'(latch_rn),  32'd1);
    check("s1_state_c8", 32'(dbg_state), 32'(ST_WAIT_CLR));
    tick(4);
    check("s1_state_c12", 32'(dbg_state), 32'(ST_IDLE));
    check("s1_count_end", 32'(evt_count), 32'd1);

    // consumer stalls for 10 cycles
    do_reset();
    pulse_set();
    tick(2);
    check("s2_valid_c3", 32'(evt_valid), 32'd1);
    tick(10);
    check("s2_valid_hold", 32'(evt_valid), 32'd1);
    check("s2_rn_hold",    32'(latch_rn),  32'd1);
    check("s2_count_hold", 32'(evt_count), 32'd0);
    evt_ready = 1'b1;
    tick(1);
    check("s2_count_acc", 32'(evt_count), 32'd1);
    check("s2_rn_acc",    32'(latch_rn),  32'd0);
    check("s2_valid_acc", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
    wait_state("s2_idle", ST_IDLE, 30);

    // dead latch: clear never shows, timeout after 4 + 3 + 16 clocks
    do_reset();
    evt_ready = 1'b1;
    pulse_set();
    tick(2);
    check("s3_valid_c3", 32'(evt_valid), 32'd1);
    dead = 1'b1;
    tick(1);
    check("s3_rn_c4", 32'(latch_rn), 32'd0);
    tick(22);
    check("s3_fault_c26", 32'(fault), 32'd0);
    tick(1);
    check("s3_fault_c27", 32'(fault),     32'd1);
    check("s3_state_c27", 32'(dbg_state), 32'(ST_FAULT));
    check("s3_rn_c27",    32'(latch_rn),  32'd1);
    check("s3_count_c27", 32'(evt_count), 32'd1);
    evt_ready = 1'b0;
    dead      = 1'b0;
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("s3_fault_clr",  32'(fault),     32'd0);
    check("s3_state_clr",  32'(dbg_state), 32'(ST_CLEAR));
    check("s3_rn_clr",     32'(latch_rn),  32'd0);
    wait_state("s3_idle", ST_IDLE, 30);
    check("s3_fault_end", 32'(fault),     32'd0);
    check("s3_count_end", 32'(evt_count), 32'd1);

    // q==qn for one clock is skew, for three clocks is a fault
    do_reset();
    bad_pat = 1'b1;
    tick(1);
    bad_pat = 1'b0;
    tick(6);
    check("s4_skew_fault", 32'(fault),     32'd0);
    check("s4_skew_state", 32'(dbg_state), 32'(ST_IDLE));
    bad_pat = 1'b1;
    tick(3);
    bad_pat = 1'b0;
    tick(4);
    check("s4_ill_fault", 32'(fault),     32'd1);
    check("s4_ill_state", 32'(dbg_state), 32'(ST_FAULT));
    check("s4_ill_count", 32'(evt_count), 32'd0);

    // 300 accepted events: counter saturates at 255
    do_reset();
    evt_ready = 1'b1;
    exp_cnt   = 0;
    for (int i = 0; i < 300; i++) begin
      pulse_set();
      tick(2);
      wait_state("s5_idle", ST_IDLE, 40);
      if (exp_cnt < 255) exp_cnt++;
      exp_q.push_back(32'(exp_cnt));
      check("s5_count", 32'(evt_count), exp_q.pop_front());
    end
    check("s5_count_sat", 32'(evt_count), 32'd255);
    evt_ready = 1'b0;

    // reset during the second CLEAR cycle
    do_reset();
    evt_ready = 1'b1;
    pulse_set();
    tick(3);
    check("s6_count_pre", 32'(evt_count), 32'd1);
    check("s6_rn_pre",    32'(latch_rn),  32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("s6_rn_rst",    32'(latch_rn),  32'd1);
    check("s6_valid_rst", 32'(evt_valid), 32'd0);
    check("s6_count_rst", 32'(evt_count), 32'd0);
    check("s6_fault_rst", 32'(fault),     32'd0);
    check("s6_state_rst", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick(6);
    check("s6_state_end", 32'(dbg_state), 32'(ST_IDLE));
    check("s6_rn_end",    32'(latch_rn),  32'd1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sr_latch_reader.md
SR_LATCH_READER -- requirements
Module: sr_latch_reader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth per latch output, minimum 2.
REQ-002 SHALL have parameter CLR_CYCLES, default 4: width in clocks of the active-low clear pulse driven to the latch, minimum 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: clocks allowed for the latch to show the cleared state, minimum 2.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port latch_q, input, 1: asynchronous Q from the external NAND SR latch.
REQ-007 SHALL have port latch_qn, input, 1: asynchronous Qn from the external NAND SR latch.
REQ-008 SHALL have port latch_rn, output, 1: active-low reset (clear) drive to the latch; registered.
REQ-009 SHALL have port evt_valid, output, 1: a captured set event is pending.
REQ-010 SHALL have port evt_ready, input, 1: the consumer accepts the event.
REQ-011 SHALL have port evt_count, output, 8: count of accepted events, saturating.
REQ-012 SHALL have port fault, output, 1: an illegal latch state was seen or the clear timed out.
REQ-013 SHALL have port fault_clr, input, 1: a single-cycle request to leave FAULT and retry the clear.

Function
REQ-014 SHALL pass latch_q and latch_qn through independent SYNC_STAGES-flop synchronizers; all decisions use only the synchronized q_s and qn_s.
REQ-015 SHALL implement states IDLE, PRESENT, CLEAR, WAIT_CLR and FAULT; latch_rn=0 only in CLEAR.
REQ-016 IDLE: if q_s=1 and qn_s=0, SHALL go to PRESENT; evt_valid rises SYNC_STAGES+1 clocks after the latch_q edge at the pin.
REQ-017 IDLE: if q_s==qn_s for 2 consecutive clocks, SHALL go to FAULT; a single-clock q_s==qn_s (switching skew) SHALL be ignored.
REQ-018 PRESENT: evt_valid SHALL be 1 and held until the clock where evt_valid and evt_ready are both 1. On that clock the block SHALL go to CLEAR and increment evt_count, saturating at 255.
REQ-019 evt_valid SHALL be 0 in every state except PRESENT; evt_ready SHALL be ignored outside PRESENT.
REQ-020 CLEAR: SHALL hold latch_rn=0 for exactly CLR_CYCLES clocks, then go to WAIT_CLR with latch_rn=1.
REQ-021 WAIT_CLR: SHALL ignore q_s/qn_s for a blanking window of SYNC_STAGES+1 clocks. After the window:
- q_s=0 and qn_s=1: go to IDLE.
- q_s=1 and qn_s=0 (set re-asserted during the clear): go to PRESENT as a new event.
- otherwise count; after TIMEOUT_CYCLES post-blank clocks without either condition, go to FAULT.
REQ-022 FAULT: fault SHALL be 1 and latch_rn=1; when fault_clr=1, SHALL go to CLEAR with fault=0 on the next clock.
REQ-023 fault SHALL be 1 only in FAULT; evt_count SHALL NOT change on fault entry or exit.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 On a clock with reset=1 the block SHALL go to IDLE with latch_rn=1, evt_valid=0, fault=0, evt_count=0 and all internal counters 0.
REQ-026 On that same clock, synchronizer flops SHALL load the idle pattern (q_s=0, qn_s=1).
REQ-027 reset asserted mid-CLEAR SHALL return latch_rn to 1 on that clock edge; the latch's current state is then re-evaluated from IDLE.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the evt_count width (8) and the parameter defaults.
REQ-029 The synchronizer SHALL be a sub-module, bit_synchronizer (parameter STAGES), instantiated once for latch_q and once for latch_qn.

Verification
REQ-030 The bench SHALL use a behavioural NAND-latch model with defaults, and SHALL cover these directed scenarios:
- Set latch at cycle 0 with evt_ready=1 -> evt_valid=1 at cycle 3, latch_rn=0 cycles 4-7, latch clears, state IDLE, evt_count=1.
- Set latch with evt_ready=0 for 10 cycles -> evt_valid held 1, latch_rn stays 1, evt_count=0; then evt_ready=1 -> evt_count=1, clear pulse follows.
- Latch model ignores latch_rn -> fault=1 after 4 clear + 3 blank + 16 cycles. Then fault_clr=1 with model fixed -> CLEAR, then IDLE, fault=0.
- Drive q=qn=1 for 1 cycle in IDLE -> no fault; drive q=qn=1 for 3 cycles -> fault=1.
- 300 accepted events -> evt_count=255, no wrap.
- Assert reset during the 2nd CLEAR cycle -> latch_rn=1 and evt_valid=0 after that edge, evt_count=0, fault=0.
